// File: rtl/decode_mux_ctrl_pkg.sv
// Shared decode-stage types: format codes, requester indices, queue entry and FSM state.
// Used by decode_mux_ctrl and decode_prio_arb.
package decode_mux_ctrl_pkg;

    localparam int NUM_FORMATS = 6;
    localparam int FIFO_DEPTH  = 4;
    localparam int ADDR_W      = 64;
    localparam int FMT_W       = 5;
    localparam int IDX_W       = $clog2(NUM_FORMATS);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [FMT_W-1:0] FMT_INVALID = 5'd0;
    localparam logic [FMT_W-1:0] FMT_D       = 5'd3;
    localparam logic [FMT_W-1:0] FMT_DQ      = 5'd4;
    localparam logic [FMT_W-1:0] FMT_DS      = 5'd5;
    localparam logic [FMT_W-1:0] FMT_MD      = 5'd9;
    localparam logic [FMT_W-1:0] FMT_X       = 5'd15;
    localparam logic [FMT_W-1:0] FMT_XO      = 5'd19;

    localparam logic [IDX_W-1:0] IDX_D  = 3'd0;
    localparam logic [IDX_W-1:0] IDX_DQ = 3'd1;
    localparam logic [IDX_W-1:0] IDX_DS = 3'd2;
    localparam logic [IDX_W-1:0] IDX_X  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_MD = 3'd4;
    localparam logic [IDX_W-1:0] IDX_XO = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACTIVE,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    function automatic logic [FMT_W-1:0] format_code(input logic [IDX_W-1:0] idx);
        logic [FMT_W-1:0] code;
        case (idx)
            IDX_D:   code = FMT_D;
            IDX_DQ:  code = FMT_DQ;
            IDX_DS:  code = FMT_DS;
            IDX_X:   code = FMT_X;
            IDX_MD:  code = FMT_MD;
            IDX_XO:  code = FMT_XO;
            default: code = FMT_INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/decode_prio_arb.sv
// Lowest-index-first priority encoder over the format decoder strobes.
// Reports one-hot grant, encoded index, any-request and multi-hot.
module decode_prio_arb #(
    parameter int N  = 6,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any,
    output logic          multi
);

    always_comb begin
        grant = '0;
        index = '0;
        // Walk downwards so the lowest set bit is the last to overwrite
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IW'(i);
            end
        end
    end

    assign any   = |req;
    assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/decode_mux_ctrl.sv
// Second decode stage scheduler: arbitrates format decoders into an in-order queue.
// Optional multi-hot rejection enabled by DECODE_MUX_CTRL_MULTIHOT_CHECK_EN.
module decode_mux_ctrl
    import decode_mux_ctrl_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [NUM_FORMATS-1:0] formatValid_i,
    input  logic [ADDR_W-1:0]      instructionAddress_i,
    input  logic                   flush_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [NUM_FORMATS-1:0] select_o,
    output logic [FMT_W-1:0]       format_o,
    output logic [ADDR_W-1:0]      instructionAddress_o,
    output logic                   stall_o,
    output logic                   overflow_o,
    output logic                   multiHot_o
);

    logic [NUM_FORMATS-1:0] grant;
    logic [IDX_W-1:0]       win_idx;
    logic                   any;
    logic                   multi;

    decode_prio_arb #(
        .N  (NUM_FORMATS),
        .IW (IDX_W)
    ) u_arb (
        .req   (formatValid_i),
        .grant (grant),
        .index (win_idx),
        .any   (any),
        .multi (multi)
    );

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    entry_t           mem [FIFO_DEPTH];
    entry_t           head_entry;

    logic req;
    logic pop;
    logic push;
    logic drop;

`ifdef DECODE_MUX_CTRL_MULTIHOT_CHECK_EN
    assign req = any && !multi;
`else
    assign req = any;
`endif

    assign pop  = valid_o && ready_i;
    assign push = req && ((count < FULL_CNT) || pop);
    assign drop = req && !push;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (push && !pop && count == FULL_CNT - CNT_W'(1))
                        state_nxt = ST_FULL;
                    else if (pop && !push && count == CNT_W'(1))
                        state_nxt = ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop && !push) state_nxt = ST_ACTIVE;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= drop && !flush_i;
            if (flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && !flush_i && push) begin
            mem[tail] <= '{idx: win_idx, addr: instructionAddress_i};
        end
    end

`ifdef DECODE_MUX_CTRL_MULTIHOT_CHECK_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            multiHot_o <= 1'b0;
        end else begin
            multiHot_o <= multi;
        end
    end
`else
    assign multiHot_o = 1'b0;
`endif

    assign head_entry = mem[head];

    always_comb begin
        valid_o              = (state != ST_EMPTY);
        stall_o              = (state == ST_FULL);
        select_o             = '0;
        format_o             = FMT_INVALID;
        instructionAddress_o = '0;
        if (valid_o) begin
            select_o             = NUM_FORMATS'(1) << head_entry.idx;
            format_o             = format_code(head_entry.idx);
            instructionAddress_o = head_entry.addr;
        end
    end

    // The winner must be exactly one of the requesting bits
    a_grant : assert property (@(posedge clock_i) disable iff (reset_i)
        $onehot0(grant) && ((grant & ~formatValid_i) == '0)
        && (multi == ($countones(formatValid_i) > 1)));

endmodule

// File: tb/tb_decode_mux_ctrl.sv
// Scoreboard bench for decode_mux_ctrl: directed stimulus pushes expectations,
// a negedge monitor pops and compares each accepted head entry.
module tb_decode_mux_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  fv;
    logic [63:0] addr;
    logic        flush;
    logic        rdy;
    logic        valid;
    logic [5:0]  sel;
    logic [4:0]  fmt;
    logic [63:0] addr_o;
    logic        stall;
    logic        ovf;
    logic        mh;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [5:0]  sel;
        logic [4:0]  fmt;
        logic [63:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    decode_mux_ctrl dut (
        .clock_i              (clk),
        .reset_i              (rst),
        .formatValid_i        (fv),
        .instructionAddress_i (addr),
        .flush_i              (flush),
        .ready_i              (rdy),
        .valid_o              (valid),
        .select_o             (sel),
        .format_o             (fmt),
        .instructionAddress_o (addr_o),
        .stall_o              (stall),
        .overflow_o           (ovf),
        .multiHot_o           (mh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && valid && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got unexpected entry %0h expected none", addr_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_sel", 64'(sel), 64'(mon_e.sel));
                check("sb_fmt", 64'(fmt), 64'(mon_e.fmt));
                check("sb_addr", addr_o, mon_e.addr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] v, input logic [63:0] a,
                         input bit accept, input logic [5:0] esel,
                         input logic [4:0] efmt);
        fv   = v;
        addr = a;
        if (accept) exp_q.push_back('{sel: esel, fmt: efmt, addr: a});
        step();
        fv = '0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_valid"}, 64'(valid), 0);
        check({tag, "_sel"}, 64'(sel), 0);
        check({tag, "_fmt"}, 64'(fmt), 0);
        check({tag, "_addr"}, addr_o, 0);
        check({tag, "_stall"}, 64'(stall), 0);
        check({tag, "_ovf"}, 64'(ovf), 0);
        check({tag, "_mh"}, 64'(mh), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        fv    = '0;
        addr  = '0;
        flush = 1'b0;
        rdy   = 1'b0;
        step();
        step();
        reset_checks("rst");
        rst = 1'b0;

        // single D request, one-cycle latency, then pop
        issue(6'b000001, 64'h1000, 1, 6'b000001, 5'd3);
        check("d_valid", 64'(valid), 1);
        rdy = 1'b1;
        step();
        check("d_popped", 64'(valid), 0);
        rdy = 1'b0;

        // fill with X requests, fifth overflows
        for (int i = 0; i < 5; i++) begin
            issue(6'b001000, 64'((i + 1) * 16), i < 4, 6'b001000, 5'd15);
            if (i == 2) check("x_stall_3", 64'(stall), 0);
            if (i == 3) check("x_stall_4", 64'(stall), 1);
        end
        check("x_ovf", 64'(ovf), 1);
        check("x_stall_hold", 64'(stall), 1);
        step();
        check("x_ovf_pulse", 64'(ovf), 0);

        // push and pop together while full
        rdy = 1'b1;
        issue(6'b100000, 64'h60, 1, 6'b100000, 5'd19);
        check("xo_stall", 64'(stall), 1);
        check("xo_ovf", 64'(ovf), 0);
        step();
        check("drain_stall", 64'(stall), 0);
        step();
        step();
        step();
        check("drain_empty", 64'(valid), 0);
        rdy = 1'b0;

        // DQ+X together
`ifdef DECODE_MUX_CTRL_MULTIHOT_CHECK_EN
        issue(6'b001010, 64'h2000, 0, 6'b000000, 5'd0);
        check("mh_pulse", 64'(mh), 1);
        check("mh_none", 64'(valid), 0);
        step();
        check("mh_clear", 64'(mh), 0);
`else
        issue(6'b001010, 64'h2000, 1, 6'b000010, 5'd4);
        check("mh_tied", 64'(mh), 0);
        check("mh_valid", 64'(valid), 1);
        step();
        check("hold_fmt", 64'(fmt), 4);
        check("hold_addr", addr_o, 64'h2000);
        rdy = 1'b1;
        step();
        check("mh_drained", 64'(valid), 0);
        rdy = 1'b0;
`endif

        // flush beats a same-cycle DS request
        issue(6'b000001, 64'h100, 1, 6'b000001, 5'd3);
        issue(6'b000010, 64'h200, 1, 6'b000010, 5'd4);
        issue(6'b010000, 64'h300, 1, 6'b010000, 5'd9);
        check("fl_pre_valid", 64'(valid), 1);
        flush = 1'b1;
        issue(6'b000100, 64'h400, 0, 6'b000000, 5'd0);
        flush = 1'b0;
        exp_q.delete();
        check("fl_valid", 64'(valid), 0);
        check("fl_stall", 64'(stall), 0);
        check("fl_sel", 64'(sel), 0);
        step();
        check("fl_no_ds", 64'(valid), 0);

        // reset while full with ready high
        for (int i = 0; i < 4; i++)
            issue(6'b010000, 64'(32'h500 + i), 1, 6'b010000, 5'd9);
        check("rf_stall", 64'(stall), 1);
        rdy = 1'b1;
        rst = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0;
        rdy = 1'b0;
        reset_checks("rf");

        step();
        check("sb_drain", 64'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_mux_ctrl.md
# decode_mux_ctrl

Scheduling controller for the second decode stage. It receives per-format valid strobes from the six parallel format decoders (D, DQ, DS, X, MD, XO) and arbitrates them to a single winner per cycle. The winner's format tag and instruction address go into a small in-order queue, which drives the one-hot select and enable of the format multiplexer under a valid/ready handshake with the downstream stage. It also raises back-pressure to the front end and supports pipeline flush.

## Interface
- numFormats, 6, number of format decoder requesters; bit order D, DQ, DS, X, MD, XO (index 0..5)
- fifoDepth, 4, queue entries; power of two, ≥2
- addressSize, 64, instruction address width
- formatIndexRange, 5, width of encoded format code

- clock_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- formatValid_i  in  numFormats  per-decoder valid strobe, index 0 = D
- instructionAddress_i  in  addressSize  address of the instruction presented this cycle
- flush_i  in  1  discard all queued entries
- ready_i  in  1  downstream accepts head entry
- valid_o  out  1  queue head valid
- select_o  out  numFormats  one-hot mux select for head entry; all zero when !valid_o
- format_o  out  formatIndexRange  encoded format of head: D=3, DQ=4, DS=5, X=15, MD=9, XO=19, INVALID=0
- instructionAddress_o  out  addressSize  address of head entry
- stall_o  out  1  queue full; front end must hold
- overflow_o  out  1  one-cycle pulse, request dropped because full
- multiHot_o  out  1  one-cycle pulse, more than one formatValid_i bit set (macro-dependent)

## Operation
- Request: any formatValid_i bit set. The winner is the lowest set index (fixed priority D > DQ > DS > X > MD > XO).
- Push: a request is accepted when (count < fifoDepth) or (pop in same cycle). It stores the winner index and instructionAddress_i at the tail.
- Pop: valid_o && ready_i. Head advances.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal when full.
- Request when full and no pop: dropped. overflow_o=1 next cycle. No state change.
- Flush: flush_i has priority over push and pop. Pointers and count go to 0, and same-cycle push and pop are ignored. valid_o=0 next cycle.
- Pointers wrap modulo fifoDepth. count is log2(fifoDepth)+1 bits.
- FSM states:
  - EMPTY (count=0): push → ACTIVE.
  - ACTIVE (0<count<fifoDepth): push reaching depth without pop → FULL; pop reaching 0 without push → EMPTY.
  - FULL: pop without push → ACTIVE.
  - flush from any state → EMPTY.
- Outputs are derived from registered head state only. select_o=onehot(head index), format_o=code(head index).

## Timing
- Reset: valid_o=0, select_o=0, format_o=0, instructionAddress_o=0, stall_o=0, overflow_o=0, multiHot_o=0, pointers/count=0, state EMPTY.
- Latency: a request in cycle N appears on valid_o/select_o in cycle N+1 if the queue was empty.
- stall_o is registered: high from the cycle after count reaches fifoDepth until the cycle after the first pop.
- ready_i may depend combinationally on nothing in this block. Outputs have no combinational path from inputs.
- A head entry is held stable while valid_o && !ready_i.
- reset_i mid-operation has the same effect as flush plus clearing the pulse outputs. It overrides flush_i.

## Configuration
- DECODE_MUX_CTRL_MULTIHOT_CHECK_EN defined: a multi-hot formatValid_i raises multiHot_o next cycle and the request is dropped (not pushed).
- Undefined: multiHot_o tied 0, and the lowest index wins silently and is pushed.

## Structure
- Shared decode package: format code constants (INVALID=0, D=3, DQ=4, DS=5, MD=9, X=15, XO=19), requester index constants, FSM state typedef.
- One sub-module: decode_prio_arb (numFormats-wide lowest-index-first priority encoder, outputs one-hot grant, index, any, multiHot).
- Queue storage and FSM stay in the top.

## Test plan
- Reset, then single D request at address 0x1000 → next cycle valid_o=1, select_o=100000, format_o=3, address 0x1000; ready_i=1 pops it, and valid_o=0 the cycle after.
- ready_i=0, five X requests (0x10..0x50) → stall_o=1 after the fourth push; the fifth request gives overflow_o pulse; draining yields 0x10..0x40 in order with format_o=15.
- Full queue, ready_i=1 and an XO request in the same cycle → accepted, count stays 4, and XO emerges last with select_o=000001, format_o=19.
- formatValid_i=010100 (DQ+X) → with macro: multiHot_o pulse, nothing queued; without macro: DQ pushed, format_o=4.
- Three entries queued, flush_i together with a DS request → next cycle valid_o=0, stall_o=0, DS not queued.
- reset_i asserted while FULL with ready_i=1 → all outputs return to reset values next cycle.
